// File: rtl/mpu_sample_framer_if.sv
// Byte-stream input and sample-stream output of the MPU-6050 sample framer.
// The framer takes the slave view; whoever feeds bytes and consumes samples takes the master view.
interface mpu_sample_framer_if;
    logic        in_valid;
    logic [3:0]  in_idx;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_axis;
    logic [15:0] out_sample;
    logic        out_last;

    modport master (
        output in_valid, in_idx, in_data, out_ready,
        input  out_valid, out_axis, out_sample, out_last
    );

    modport slave (
        input  in_valid, in_idx, in_data, out_ready,
        output out_valid, out_axis, out_sample, out_last
    );
endinterface

// File: rtl/mpu_sample_framer.sv
// Pairs MPU-6050 register bytes into a 6-axis frame and streams it one axis per beat.
// Optional per-axis IIR smoothing is enabled by defining MPU_IIR_FILTER_EN.
module mpu_sample_framer #(
    parameter int IIR_SHIFT  = 2,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mpu_sample_framer_if.slave    bus,
    output logic                  err_seq,
    output logic                  overrun,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic [15:0]           frame_cnt
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [3:0] LAST_IDX  = 4'd11;
    localparam logic [2:0] LAST_AXIS = 3'd5;

    if (IIR_SHIFT < 0 || IIR_SHIFT > 7) begin : g_bad_shift
        $error("IIR_SHIFT must be in 0..7");
    end

    logic [3:0]  expect_idx;
    logic [7:0]  hi_byte;
    logic [15:0] cap       [0:5];
    logic [15:0] frame_raw [0:5];
    logic [15:0] frame_out [0:5];
    logic [15:0] obuf      [0:5];

    state_t      state_q, state_d;
    logic [2:0]  axis_q, axis_d;

    logic        accept, frame_done, out_hs, finishing, load, drop;

    // ------------------------------------------------------------------
    // Capture side: sequence check and high/low byte pairing
    // ------------------------------------------------------------------
    always_comb begin
        accept     = bus.in_valid && (bus.in_idx == expect_idx);
        frame_done = accept && (bus.in_idx == LAST_IDX);
        for (int i = 0; i < 5; i++) begin
            frame_raw[i] = cap[i];
        end
        // The Z-gyro sample is still being written this cycle; take it live.
        frame_raw[5] = {hi_byte, bus.in_data};
    end

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expect_idx <= '0;
            hi_byte    <= '0;
            for (int i = 0; i < 6; i++) begin
                cap[i] <= '0;
            end
        end else if (bus.in_valid) begin
            if (accept) begin
                if (!bus.in_idx[0]) begin
                    hi_byte <= bus.in_data;
                end else begin
                    cap[bus.in_idx[3:1]] <= {hi_byte, bus.in_data};
                end
                expect_idx <= (bus.in_idx == LAST_IDX) ? 4'd0 : expect_idx + 4'd1;
            end else if (bus.in_idx == 4'd0) begin
                // Out-of-order byte that looks like a frame start restarts the frame.
                hi_byte    <= bus.in_data;
                expect_idx <= 4'd1;
            end else begin
                expect_idx <= 4'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load decision: the output buffer is free when idle or on its last beat
    // ------------------------------------------------------------------
    always_comb begin
        out_hs    = (state_q == STREAM) && bus.out_ready;
        finishing = out_hs && (axis_q == LAST_AXIS);
        load      = frame_done && ((state_q == IDLE) || finishing);
        drop      = frame_done && !load;
    end

`ifdef MPU_IIR_FILTER_EN
    logic signed [15:0] filt      [0:5];
    logic signed [15:0] filt_next [0:5];
    logic signed [16:0] filt_diff [0:5];
    logic signed [16:0] filt_step [0:5];
    logic               seeded;

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            filt_diff[i] = $signed({frame_raw[i][15], frame_raw[i]}) - $signed({filt[i][15], filt[i]});
            filt_step[i] = filt_diff[i] >>> IIR_SHIFT;
            filt_next[i] = seeded ? filt[i] + filt_step[i][15:0] : $signed(frame_raw[i]);
            frame_out[i] = filt_next[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seeded <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                filt[i] <= '0;
            end
        end else if (load) begin
            seeded <= 1'b1;
            for (int i = 0; i < 6; i++) begin
                filt[i] <= filt_next[i];
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            frame_out[i] = frame_raw[i];
        end
    end
`endif

    // NOTE: obuf is a data array with no reset; out_sample is gated by out_valid so stale contents never escape.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 6; i++) begin
                obuf[i] <= frame_out[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            axis_q  <= '0;
        end else begin
            state_q <= state_d;
            axis_q  <= axis_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        axis_d  = axis_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = STREAM;
                    axis_d  = '0;
                end
            end
            STREAM: begin
                if (out_hs) begin
                    if (axis_q == LAST_AXIS) begin
                        // A coincident load keeps streaming without a bubble.
                        axis_d  = '0;
                        state_d = load ? STREAM : IDLE;
                    end else begin
                        axis_d = axis_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                axis_d  = '0;
            end
        endcase
    end

    always_comb begin
        bus.out_valid  = (state_q == STREAM);
        bus.out_axis   = axis_q;
        bus.out_last   = bus.out_valid && (axis_q == LAST_AXIS);
        bus.out_sample = bus.out_valid ? obuf[axis_q] : 16'h0000;
    end

    // ------------------------------------------------------------------
    // Status pulses and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_seq   <= 1'b0;
            overrun   <= 1'b0;
            drop_cnt  <= '0;
            frame_cnt <= '0;
        end else begin
            err_seq <= bus.in_valid && !accept;
            overrun <= drop;
            if (drop && (drop_cnt != {DROP_CNT_W{1'b1}})) begin
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
            if (load) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule
